// File: rtl/systolic_operand_feeder.sv
// Operand staging buffer feeding a systolic MAC array: per-lane A/B element
// buffers popped one element per enabled lane on each control load pulse.
module systolic_operand_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned M  = 2,
  parameter int unsigned K  = 4,
  parameter int unsigned DW = 8,
  localparam int unsigned NL = (N > M) ? N : M,
  localparam int unsigned LW = (NL > 1) ? $clog2(NL) : 1,
  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned KW = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [LW-1:0]   wr_lane,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [KW-1:0]   k_len,
  input  logic            arm,
  input  logic            clear,
  input  logic            load,
  input  logic [N-1:0]    A_start_en,
  input  logic [M-1:0]    B_start_en,
  output logic [N*DW-1:0] a_data,
  output logic [N-1:0]    a_valid,
  output logic [M*DW-1:0] b_data,
  output logic [M-1:0]    b_valid,
  output logic            finished,
  output logic            wr_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DW-1:0]     r_a_buf [N][K];
  logic [DW-1:0]     r_b_buf [M][K];
  logic [KW-1:0]     r_a_ptr [N];
  logic [KW-1:0]     r_b_ptr [M];
  logic [KW-1:0]     r_k_len_q;
  logic [N*DW-1:0]   r_a_data;
  logic [N-1:0]      r_a_valid;
  logic [M*DW-1:0]   r_b_data;
  logic [M-1:0]      r_b_valid;
  logic              r_finished;
  logic              r_wr_err;
  logic              w_lane0_done;

  assign w_lane0_done = (r_a_ptr[0] == r_k_len_q) && (r_b_ptr[0] == r_k_len_q);

  // Operand storage is deliberately left out of reset so a re-arm replays it.
  always_ff @(posedge clk) begin
    if (wr_en && r_state == S_IDLE) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < K; k++) begin
          if (!wr_sel && wr_lane == LW'(i) && wr_addr == AW'(k)) r_a_buf[i][k] <= wr_data;
        end
      end
      for (int j = 0; j < M; j++) begin
        for (int k = 0; k < K; k++) begin
          if (wr_sel && wr_lane == LW'(j) && wr_addr == AW'(k)) r_b_buf[j][k] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k_len_q  <= '0;
      r_a_data   <= '0;
      r_a_valid  <= '0;
      r_b_data   <= '0;
      r_b_valid  <= '0;
      r_finished <= 1'b0;
      r_wr_err   <= 1'b0;
      for (int i = 0; i < N; i++) r_a_ptr[i] <= '0;
      for (int j = 0; j < M; j++) r_b_ptr[j] <= '0;
    end else begin
      if (wr_en && r_state != S_IDLE) r_wr_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_k_len_q  <= (k_len > KW'(K)) ? KW'(K) : k_len;
            r_a_data   <= '0;
            r_a_valid  <= '0;
            r_b_data   <= '0;
            r_b_valid  <= '0;
            r_finished <= 1'b0;
            for (int i = 0; i < N; i++) r_a_ptr[i] <= '0;
            for (int j = 0; j < M; j++) r_b_ptr[j] <= '0;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM, S_DONE: begin
          // Lanes not popping on a load present a zero operand to the array.
          if (load) begin
            for (int i = 0; i < N; i++) begin
              if (A_start_en[i] && r_a_ptr[i] < r_k_len_q) begin
                r_a_data[i*DW +: DW] <= r_a_buf[i][AW'(r_a_ptr[i])];
                r_a_valid[i]         <= 1'b1;
                r_a_ptr[i]           <= r_a_ptr[i] + KW'(1);
              end else begin
                r_a_data[i*DW +: DW] <= '0;
                r_a_valid[i]         <= 1'b0;
              end
            end
            for (int j = 0; j < M; j++) begin
              if (B_start_en[j] && r_b_ptr[j] < r_k_len_q) begin
                r_b_data[j*DW +: DW] <= r_b_buf[j][AW'(r_b_ptr[j])];
                r_b_valid[j]         <= 1'b1;
                r_b_ptr[j]           <= r_b_ptr[j] + KW'(1);
              end else begin
                r_b_data[j*DW +: DW] <= '0;
                r_b_valid[j]         <= 1'b0;
              end
            end
          end
          if (r_state == S_STREAM && w_lane0_done) begin
            r_state    <= S_DONE;
            r_finished <= 1'b1;
          end
          if (r_state == S_DONE && clear) begin
            r_state    <= S_IDLE;
            r_finished <= 1'b0;
            r_a_data   <= '0;
            r_a_valid  <= '0;
            r_b_data   <= '0;
            r_b_valid  <= '0;
            for (int i = 0; i < N; i++) r_a_ptr[i] <= '0;
            for (int j = 0; j < M; j++) r_b_ptr[j] <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_data   = r_a_data;
  assign a_valid  = r_a_valid;
  assign b_data   = r_b_data;
  assign b_valid  = r_b_valid;
  assign finished = r_finished;
  assign wr_err   = r_wr_err;

endmodule
